// File: rtl/kc_tap_upload.sv
// KC85 TAP upload source: serves a 16-byte KC-TAPE header and 129-byte blocks to hps_io.
// Optional macro KC_TAP_UPLOAD_TIMEOUT_EN enables a per-fetch memory timeout that sets err.
module kc_tap_upload #(
  parameter logic [7:0]  UPLOAD_INDEX = 8'd1,
  parameter int unsigned BLK_LEN      = 128,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  input  logic [15:0] start_addr,
  input  logic [15:0] length,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic        busy,
  output logic        err
);

  localparam int unsigned     POS_W    = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(BLK_LEN - 1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [15:0]      BLK_LEN16 = 16'(BLK_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_BLKNUM,
    S_DATA,
    S_FETCH,
    S_END
  } state_t;

  state_t           state_q, state_d;
  logic             active_q;
  logic [15:0]      start_q, start_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      ptr_q, ptr_d;
  logic [15:0]      rem_q, rem_d;
  logic [3:0]       hdr_pos_q, hdr_pos_d;
  logic [7:0]       blk_no_q, blk_no_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             last_q, last_d;
  logic [7:0]       din_q, din_d;
  logic             req_q, req_d;
  logic [15:0]      maddr_q, maddr_d;
  logic             busy_q, busy_d;

`ifdef KC_TAP_UPLOAD_TIMEOUT_EN
  localparam int unsigned  CNT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  logic active;
  logic rd_ok;
  logic adv;
  logic wait_c;

  assign active = ioctl_upload && (ioctl_index == UPLOAD_INDEX);

  function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'hC3;
      4'd1:    return 8'h4B;
      4'd2:    return 8'h43;
      4'd3:    return 8'h2D;
      4'd4:    return 8'h54;
      4'd5:    return 8'h41;
      4'd6:    return 8'h50;
      4'd7:    return 8'h45;
      4'd8:    return 8'h20;
      4'd9:    return 8'h62;
      4'd10:   return 8'h79;
      4'd11:   return 8'h20;
      4'd12:   return 8'h41;
      4'd13:   return 8'h46;
      4'd14:   return 8'h2E;
      default: return 8'h20;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    len_d     = len_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    hdr_pos_d = hdr_pos_q;
    blk_no_d  = blk_no_q;
    pos_d     = pos_q;
    last_d    = last_q;
    din_d     = din_q;
    req_d     = req_q;
    maddr_d   = maddr_q;
    busy_d    = busy_q;
`ifdef KC_TAP_UPLOAD_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    rd_ok     = 1'b0;
    adv       = 1'b0;
    wait_c    = 1'b0;

    if (!active) begin
      state_d = S_IDLE;
      req_d   = 1'b0;
      busy_d  = 1'b0;
    end else if (!active_q) begin
      start_d   = start_addr;
      len_d     = length;
      ptr_d     = start_addr;
      rem_d     = length;
      hdr_pos_d = 4'd0;
      blk_no_d  = 8'd1;
      pos_d     = '0;
      last_d    = 1'b0;
      busy_d    = 1'b1;
      state_d   = S_HDR;
`ifdef KC_TAP_UPLOAD_TIMEOUT_EN
      err_d     = 1'b0;
`endif
    end else begin
      // Reads during an outstanding fetch are dropped; offset 0 rewinds the stream.
      rd_ok = ioctl_rd && (state_q != S_FETCH) && (state_q != S_IDLE);
      if (rd_ok && (ioctl_addr == 25'd0)) begin
        ptr_d     = start_q;
        rem_d     = len_q;
        hdr_pos_d = 4'd0;
        blk_no_d  = 8'd1;
        pos_d     = '0;
        last_d    = 1'b0;
        state_d   = S_HDR;
      end

      case (state_d)
        S_HDR: begin
          if (rd_ok) begin
            din_d = hdr_byte(hdr_pos_d);
            if (hdr_pos_d == 4'd15) begin
              state_d = S_BLKNUM;
            end else begin
              hdr_pos_d = hdr_pos_d + 4'd1;
            end
          end
        end
        S_BLKNUM: begin
          if (rd_ok) begin
            last_d  = (rem_d <= BLK_LEN16);
            din_d   = last_d ? 8'hFF : blk_no_d;
            pos_d   = '0;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (rd_ok) begin
            if (rem_d != 16'd0) begin
              wait_c  = 1'b1;
              req_d   = 1'b1;
              maddr_d = ptr_d;
              ptr_d   = ptr_d + 16'd1;
              state_d = S_FETCH;
`ifdef KC_TAP_UPLOAD_TIMEOUT_EN
              cnt_d   = '0;
`endif
            end else begin
              din_d = 8'h00;
              adv   = 1'b1;
            end
          end
        end
        S_FETCH: begin
          wait_c = 1'b1;
          if (mem_ack && req_q) begin
            din_d = mem_data;
            req_d = 1'b0;
            rem_d = rem_d - 16'd1;
            adv   = 1'b1;
`ifdef KC_TAP_UPLOAD_TIMEOUT_EN
          end else if (cnt_q == CNT_MAX) begin
            din_d = 8'hFF;
            err_d = 1'b1;
            req_d = 1'b0;
            rem_d = rem_d - 16'd1;
            adv   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
`endif
          end
        end
        S_END: begin
          if (rd_ok) begin
            din_d = 8'h00;
          end
        end
        default: begin
        end
      endcase

      // A delivered data or pad byte advances within the block, then to the next block.
      if (adv) begin
        if (pos_d == POS_LAST) begin
          if (last_d) begin
            state_d = S_END;
          end else begin
            blk_no_d = blk_no_d + 8'd1;
            state_d  = S_BLKNUM;
          end
        end else begin
          pos_d   = pos_d + POS_ONE;
          state_d = S_DATA;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      active_q  <= 1'b0;
      start_q   <= 16'd0;
      len_q     <= 16'd0;
      ptr_q     <= 16'd0;
      rem_q     <= 16'd0;
      hdr_pos_q <= 4'd0;
      blk_no_q  <= 8'd1;
      pos_q     <= '0;
      last_q    <= 1'b0;
      din_q     <= 8'h00;
      req_q     <= 1'b0;
      maddr_q   <= 16'd0;
      busy_q    <= 1'b0;
`ifdef KC_TAP_UPLOAD_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      active_q  <= active;
      start_q   <= start_d;
      len_q     <= len_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      hdr_pos_q <= hdr_pos_d;
      blk_no_q  <= blk_no_d;
      pos_q     <= pos_d;
      last_q    <= last_d;
      din_q     <= din_d;
      req_q     <= req_d;
      maddr_q   <= maddr_d;
      busy_q    <= busy_d;
`ifdef KC_TAP_UPLOAD_TIMEOUT_EN
      cnt_q     <= cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_c;
  assign mem_req    = req_q;
  assign mem_addr   = maddr_q;
  assign busy       = busy_q;
`ifdef KC_TAP_UPLOAD_TIMEOUT_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_kc_tap_upload.sv
// Scoreboard bench for kc_tap_upload: stimulus queues expected bytes, a monitor pops them.
`timescale 1ns/1ps
module tb_kc_tap_upload;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [15:0] start_addr = 16'd0;
  logic [15:0] length = 16'd0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic        busy;
  logic        err;

  kc_tap_upload dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .start_addr(start_addr), .length(length),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data),
    .busy(busy), .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct { logic [7:0] val; int idx; } exp_t;
  exp_t        exp_q[$];
  logic [15:0] addr_q[$];
  int n_vec = 0;
  int n_err = 0;
  bit track = 1'b1;
  bit mem_en = 1'b1;
  bit force_ack = 1'b0;
  int req_cnt = 0;

  localparam int ACK_DLY = 2;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    case (a)
      16'h0300: return 8'h11;
      16'h0301: return 8'h22;
      16'h0302: return 8'h33;
      default:  return a[7:0] + a[15:8] + 8'h17;
    endcase
  endfunction

  function automatic logic [7:0] hdr_ref(input int i);
    logic [7:0] h [16] = '{8'hC3, 8'h4B, 8'h43, 8'h2D, 8'h54, 8'h41, 8'h50, 8'h45,
                           8'h20, 8'h62, 8'h79, 8'h20, 8'h41, 8'h46, 8'h2E, 8'h20};
    return h[i];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Expected content of stream byte k for an upload of l bytes from s.
  task automatic exp_info(input int k, input logic [15:0] s, input logic [15:0] l,
                          output logic [7:0] e, output bit fetch, output logic [15:0] a);
    int nblk, j, b, o, d;
    nblk  = (l == 16'd0) ? 1 : (int'(l) + 127) / 128;
    fetch = 1'b0;
    a     = 16'd0;
    if (k < 16) begin
      e = hdr_ref(k);
    end else begin
      j = k - 16; b = j / 129; o = j % 129;
      if (b >= nblk) begin
        e = 8'h00;
      end else if (o == 0) begin
        e = (b == nblk - 1) ? 8'hFF : 8'(b + 1);
      end else begin
        d = b * 128 + o - 1;
        if (d < int'(l)) begin
          a = 16'(int'(s) + d);
          e = mem_byte(a);
          fetch = 1'b1;
        end else begin
          e = 8'h00;
        end
      end
    end
  endtask

  // mode 0: no fetch, 1: fetch with ack (wait length checked), 2: fetch expected to time out
  task automatic rd_track(input int k, input logic [7:0] e, input int mode, input logic [15:0] a);
    exp_t x;
    int wcnt, lim;
    bit done;
    x.val = e; x.idx = k;
    if (mode == 1) addr_q.push_back(a);
    exp_q.push_back(x);
    @(posedge clk_sys); #1;
    ioctl_addr = 25'(k); ioctl_rd = 1'b1;
    @(negedge clk_sys);
    wcnt = ioctl_wait ? 1 : 0;
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0;
    lim = (mode == 2) ? 600 : 40;
    done = 1'b0;
    for (int c = 0; c < lim && !done; c++) begin
      @(negedge clk_sys);
      if (!ioctl_wait) done = 1'b1; else wcnt++;
    end
    if (!done) chk($sformatf("wait_release[%0d]", k), 32'd0, 32'd1);
    if (mode == 1) chk($sformatf("wait_cycles[%0d]", k), 32'(wcnt), 32'd3);
  endtask

  task automatic rd_raw(input int k);
    track = 1'b0;
    @(posedge clk_sys); #1;
    ioctl_addr = 25'(k); ioctl_rd = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk_sys);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic start_upload(input logic [15:0] s, input logic [15:0] l);
    @(posedge clk_sys); #1;
    start_addr = s; length = l; ioctl_index = 8'd1; ioctl_upload = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("err_after_start", 32'(err), 32'd0);
  endtask

  task automatic stop_upload();
    @(posedge clk_sys); #1;
    ioctl_upload = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("busy_after_stop", 32'(busy), 32'd0);
    chk("mem_req_after_stop", 32'(mem_req), 32'd0);
  endtask

  task automatic read_range(input int k0, input int k1, input logic [15:0] s, input logic [15:0] l);
    logic [7:0] e; bit f; logic [15:0] a;
    for (int k = k0; k < k1; k++) begin
      exp_info(k, s, l, e, f, a);
      rd_track(k, e, f ? 1 : 0, a);
    end
  endtask

  task automatic run_upload(input logic [15:0] s, input logic [15:0] l);
    int nblk, total, base;
    nblk  = (l == 16'd0) ? 1 : (int'(l) + 127) / 128;
    total = 16 + nblk * 129;
    base  = req_cnt;
    start_upload(s, l);
    read_range(0, total + 1, s, l);
    drain();
    chk("mem_req_count", 32'(req_cnt - base), 32'(l));
    stop_upload();
  endtask

  // Monitor: a tracked read completes at the first sample with ioctl_wait low.
  initial begin
    bit pend = 1'b0;
    exp_t x;
    forever begin
      @(posedge clk_sys);
      if (ioctl_rd && track) pend = 1'b1;
      @(negedge clk_sys);
      if (pend && !ioctl_wait) begin
        pend = 1'b0;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL byte_unexpected: got %h want none", ioctl_din);
        end else begin
          x = exp_q.pop_front();
          if (ioctl_din !== x.val) begin
            n_err++;
            $display("FAIL byte[%0d]: got %h want %h", x.idx, ioctl_din, x.val);
          end
        end
      end
    end
  end

  // Memory model: acks on the ACK_DLY-th cycle of mem_req and checks the address.
  initial begin
    int hold = 0;
    bit prev = 1'b0;
    logic [15:0] ea;
    mem_ack = 1'b0; mem_data = 8'h00;
    forever begin
      @(negedge clk_sys);
      if (mem_req && !prev) req_cnt++;
      prev = mem_req;
      if (force_ack) begin
        mem_ack = 1'b1; mem_data = 8'h77;
      end else if (mem_req && mem_en) begin
        hold++;
        if (hold == ACK_DLY) begin
          mem_ack = 1'b1; mem_data = mem_byte(mem_addr);
          n_vec++;
          if (addr_q.size() == 0) begin
            n_err++;
            $display("FAIL mem_addr_unexpected: got %h want none", mem_addr);
          end else begin
            ea = addr_q.pop_front();
            if (mem_addr !== ea) begin
              n_err++;
              $display("FAIL mem_addr: got %h want %h", mem_addr, ea);
            end
          end
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        hold = 0; mem_ack = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_sys);
    chk("rst_din", 32'(ioctl_din), 32'h00);
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset_n = 1'b1;

    // Wrong index must not start an upload.
    @(posedge clk_sys); #1;
    ioctl_index = 8'd2; ioctl_upload = 1'b1;
    repeat (2) @(negedge clk_sys);
    chk("busy_wrong_index", 32'(busy), 32'd0);
    @(posedge clk_sys); #1;
    ioctl_upload = 1'b0;

    run_upload(16'h0300, 16'd3);
    run_upload(16'h1000, 16'd200);
    run_upload(16'hFFFF, 16'd2);
    run_upload(16'h2000, 16'd0);

    // Upload dropped while a fetch is outstanding; a late ack must change nothing.
    start_upload(16'h0300, 16'd5);
    read_range(0, 17, 16'h0300, 16'd5);
    drain();
    mem_en = 1'b0;
    rd_raw(17);
    repeat (2) @(negedge clk_sys);
    chk("drop_mem_req_pending", 32'(mem_req), 32'd1);
    @(posedge clk_sys); #1;
    ioctl_upload = 1'b0;
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("drop_mem_req", 32'(mem_req), 32'd0);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_wait", 32'(ioctl_wait), 32'd0);
    @(posedge clk_sys); #1;
    force_ack = 1'b1;
    @(posedge clk_sys); #1;
    force_ack = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("late_ack_din", 32'(ioctl_din), 32'hFF);
    chk("late_ack_mem_req", 32'(mem_req), 32'd0);
    mem_en = 1'b1; track = 1'b1;

    // Reset asserted mid-fetch, then a fresh upload from the header.
    start_upload(16'h0300, 16'd3);
    read_range(0, 17, 16'h0300, 16'd3);
    drain();
    mem_en = 1'b0;
    rd_raw(17);
    repeat (2) @(negedge clk_sys);
    chk("mid_fetch_mem_req", 32'(mem_req), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_din", 32'(ioctl_din), 32'h00);
    chk("async_rst_wait", 32'(ioctl_wait), 32'd0);
    chk("async_rst_mem_req", 32'(mem_req), 32'd0);
    chk("async_rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_err", 32'(err), 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    mem_en = 1'b1; track = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_sys);
      chk("post_rst_mem_req", 32'(mem_req), 32'd0);
    end
    chk("post_rst_busy", 32'(busy), 32'd1);
    read_range(0, 16, 16'h0300, 16'd3);
    drain();
    stop_upload();

`ifdef KC_TAP_UPLOAD_TIMEOUT_EN
    start_upload(16'h0300, 16'd3);
    read_range(0, 17, 16'h0300, 16'd3);
    drain();
    mem_en = 1'b0;
    rd_track(17, 8'hFF, 2, 16'h0300);
    drain();
    chk("timeout_err", 32'(err), 32'd1);
    stop_upload();
    mem_en = 1'b1;
    start_upload(16'h0300, 16'd3);
    stop_upload();
`endif

    repeat (4) @(negedge clk_sys);
    chk("addr_queue_empty", 32'(addr_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
